// File: rtl/axilrom_pkg.sv
// Shared constants for the AXI-lite instruction ROM: response codes, the
// instruction bit of ARPROT, and the response-selection helper.
package axilrom_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         PROT_INSN   = 2;

    function automatic logic [1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axilrom_if.sv
// AXI-lite read channels (AR and R) between the fetch unit and the ROM.
interface axilrom_if #(
    parameter int AW = 32,
    parameter int DW = 64
);
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;

    modport master (
        output arvalid, araddr, arprot, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  arvalid, araddr, arprot, rready,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axilrom_skidbuffer.sv
// Single-entry skid buffer: registered ready, combinational pass-through
// while empty, holds one captured beat when the downstream stalls.
module axilrom_skidbuffer #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data
);
    logic          full_r;
    logic [DW-1:0] buf_r;

    // Occupancy: fill when an accepted beat cannot move on, drain on ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_r <= 1'b0;
        end else if (i_valid && !full_r && !i_ready) begin
            full_r <= 1'b1;
        end else if (i_ready) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

    // Track the input while empty so the stalled beat is already captured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_r <= {DW{1'b0}};
        end else if (!full_r) begin
            buf_r <= i_data;
        end else begin
            buf_r <= buf_r;
        end
    end

    assign o_ready = !full_r;
    assign o_valid = i_valid || full_r;
    assign o_data  = full_r ? buf_r : i_data;

endmodule

// File: rtl/axilrom.sv
// AXI-lite read-only instruction memory with a side-band word load port.
// One read per clock, in-order responses, SLVERR for out-of-range/data reads.
module axilrom
    import axilrom_pkg::*;
#(
    parameter int   C_AXI_ADDR_WIDTH = 32,
    parameter int   C_AXI_DATA_WIDTH = 64,
    parameter int   LGMEMSZ          = 12,
    parameter logic OPT_SKIDBUFFER   = 1'b1,
    parameter logic OPT_INSN_ONLY    = 1'b1,
    parameter logic OPT_LOWPOWER     = 1'b0
) (
    input  logic                       S_AXI_ACLK,
    input  logic                       S_AXI_ARESETN,
    axilrom_if.slave                   s_axi,
    input  logic                       i_ld_we,
    input  logic [LGMEMSZ-$clog2(C_AXI_DATA_WIDTH/8)-1:0] i_ld_addr,
    input  logic [C_AXI_DATA_WIDTH-1:0] i_ld_data
);
    localparam int AW      = C_AXI_ADDR_WIDTH;
    localparam int DW      = C_AXI_DATA_WIDTH;
    localparam int AXILLSB = $clog2(C_AXI_DATA_WIDTH/8);
    localparam int IW      = LGMEMSZ - AXILLSB;
    localparam int NWORDS  = 1 << IW;

    logic          rd_valid_s;
    logic          rd_ready_s;
    logic [AW-1:0] rd_addr_s;
    logic [2:0]    rd_prot_s;
    logic          ar_ready_s;
    logic          issue_s;
    logic          err_s;
    logic [IW-1:0] idx_s;
    logic          unused_s;

    logic          rvalid_r;
    logic [1:0]    rresp_r;
    logic [DW-1:0] rdata_r;
    logic [DW-1:0] mem_r [0:NWORDS-1];

    generate
        if (OPT_SKIDBUFFER) begin : g_skid
            logic [AW+2:0] sk_data_s;

            axilrom_skidbuffer #(
                .DW(AW + 3)
            ) u_skid (
                .clk     (S_AXI_ACLK),
                .rst_n   (S_AXI_ARESETN),
                .i_valid (s_axi.arvalid),
                .o_ready (ar_ready_s),
                .i_data  ({s_axi.arprot, s_axi.araddr}),
                .o_valid (rd_valid_s),
                .i_ready (rd_ready_s),
                .o_data  (sk_data_s)
            );

            assign rd_prot_s = sk_data_s[AW+2:AW];
            assign rd_addr_s = sk_data_s[AW-1:0];
        end else begin : g_direct
            assign rd_valid_s = s_axi.arvalid;
            assign rd_addr_s  = s_axi.araddr;
            assign rd_prot_s  = s_axi.arprot;
            assign ar_ready_s = rd_ready_s;
        end
    endgenerate

    assign rd_ready_s = !rvalid_r || s_axi.rready;
    assign issue_s    = rd_valid_s && rd_ready_s;
    assign idx_s      = rd_addr_s[LGMEMSZ-1:AXILLSB];
    assign err_s      = (|rd_addr_s[AW-1:LGMEMSZ])
                     || (OPT_INSN_ONLY && !rd_prot_s[PROT_INSN]);
    assign unused_s   = &{1'b0, rd_addr_s[AXILLSB-1:0], rd_prot_s[1:0]};

    // Load port: boot image writes, never reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (i_ld_we) begin
            mem_r[i_ld_addr] <= i_ld_data;
        end
    end

    // R channel register; memory is only read on issue so a stall holds data.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rvalid_r <= 1'b0;
            rresp_r  <= RESP_OKAY;
            rdata_r  <= {DW{1'b0}};
        end else if (issue_s) begin
            rvalid_r <= 1'b1;
            rresp_r  <= resp_of(err_s);
            rdata_r  <= err_s ? {DW{1'b0}} : mem_r[idx_s];
        end else if (s_axi.rready) begin
            rvalid_r <= 1'b0;
            if (OPT_LOWPOWER) begin
                rresp_r <= RESP_OKAY;
                rdata_r <= {DW{1'b0}};
            end else begin
                rresp_r <= rresp_r;
                rdata_r <= rdata_r;
            end
        end else begin
            rvalid_r <= rvalid_r;
            rresp_r  <= rresp_r;
            rdata_r  <= rdata_r;
        end
    end

    assign s_axi.arready = ar_ready_s;
    assign s_axi.rvalid  = rvalid_r;
    assign s_axi.rresp   = rresp_r;
    assign s_axi.rdata   = rdata_r;

endmodule

// File: tb/tb_axilrom.sv
// Directed bench for axilrom: default build plus a second build without
// the skid buffer, with data reads allowed and low-power RDATA.
module tb_axilrom;
    logic        clk = 1'b0;
    logic        aresetn;
    logic        ld_we, ld_we_d;
    logic [8:0]  ld_addr, ld_addr_d;
    logic [63:0] ld_data, ld_data_d;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] W0 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] W1 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] W2 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] W3 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] W5 = 64'h5555_5555_5555_5555;
    localparam logic [63:0] WN = 64'hDEAD_BEEF_0BAD_F00D;

    axilrom_if #(.AW(32), .DW(64)) bus ();
    axilrom_if #(.AW(32), .DW(64)) bus_d ();

    axilrom dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (aresetn),
        .s_axi         (bus),
        .i_ld_we       (ld_we),
        .i_ld_addr     (ld_addr),
        .i_ld_data     (ld_data)
    );

    axilrom #(
        .OPT_SKIDBUFFER (1'b0),
        .OPT_INSN_ONLY  (1'b0),
        .OPT_LOWPOWER   (1'b1)
    ) dut_d (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (aresetn),
        .s_axi         (bus_d),
        .i_ld_we       (ld_we_d),
        .i_ld_addr     (ld_addr_d),
        .i_ld_data     (ld_data_d)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Single read on the default DUT; expects bus idle with RREADY high.
    task automatic do_read(input string tag, input logic [31:0] addr, input logic [2:0] prot,
                           input logic [63:0] exp_d, input logic [1:0] exp_r);
        step();
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
        bus.arprot  = prot;
        step();
        bus.arvalid = 1'b0;
        @(negedge clk);
        check({tag, "_rvalid"}, {63'd0, bus.rvalid}, 64'd1);
        check({tag, "_rdata"}, bus.rdata, exp_d);
        check({tag, "_rresp"}, {62'd0, bus.rresp}, {62'd0, exp_r});
    endtask

    logic [31:0] s_addr [6];
    logic [63:0] s_data [6];
    logic [1:0]  s_resp [6];
    bit          pat [7];
    logic [63:0] exp_q [$];
    logic [1:0]  expr_q [$];

    initial begin
        int req_i, got, outst, cyc;
        bit prev_stall, saw_full, hs, beat;
        logic [63:0] held_d;
        logic [1:0]  held_r;

        s_addr = '{32'h0000_0000, 32'h0000_0008, 32'h0000_0010,
                   32'h0000_0018, 32'h0000_0FF8, 32'h0000_1000};
        s_data = '{W0, W1, W2, W3, W5, 64'd0};
        s_resp = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
        pat    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        aresetn = 1'b0;
        ld_we = 1'b0; ld_addr = 9'd0; ld_data = 64'd0;
        ld_we_d = 1'b0; ld_addr_d = 9'd0; ld_data_d = 64'd0;
        bus.arvalid = 1'b0; bus.araddr = 32'd0; bus.arprot = 3'b100; bus.rready = 1'b1;
        bus_d.arvalid = 1'b0; bus_d.araddr = 32'd0; bus_d.arprot = 3'b000; bus_d.rready = 1'b1;

        step();
        step();
        aresetn = 1'b1;
        @(negedge clk);
        check("rst_rvalid", {63'd0, bus.rvalid}, 64'd0);
        check("rst_rresp", {62'd0, bus.rresp}, 64'd0);
        check("rst_arready", {63'd0, bus.arready}, 64'd1);
        check("rst_d_rdata", bus_d.rdata, 64'd0);

        // Boot image load through the side-band port.
        for (int i = 0; i < 5; i++) begin
            step();
            ld_we   = 1'b1;
            ld_addr = (i == 4) ? 9'd511 : 9'(i);
            ld_data = (i == 0) ? W0 : (i == 1) ? W1 : (i == 2) ? W2 : (i == 3) ? W3 : W5;
        end
        step();
        ld_we = 1'b0;
        ld_we_d = 1'b1; ld_addr_d = 9'd1; ld_data_d = W1;
        step();
        ld_we_d = 1'b0;

        // Back-to-back reads, one beat per clock.
        for (int k = 0; k < 5; k++) begin
            step();
            if (k < 4) begin
                bus.arvalid = 1'b1;
                bus.araddr  = 32'(k * 8);
                bus.arprot  = 3'b100;
            end else begin
                bus.arvalid = 1'b0;
            end
            @(negedge clk);
            if (k > 0) begin
                check("b2b_rvalid", {63'd0, bus.rvalid}, 64'd1);
                check("b2b_rdata", bus.rdata, s_data[k-1]);
                check("b2b_rresp", {62'd0, bus.rresp}, 64'd0);
            end
        end
        step();
        @(negedge clk);
        check("b2b_idle", {63'd0, bus.rvalid}, 64'd0);

        do_read("oob", 32'h0000_1000, 3'b100, 64'd0, 2'b10);
        do_read("top", 32'h0000_0FF8, 3'b100, W5, 2'b00);
        do_read("data", 32'h0000_0008, 3'b000, 64'd0, 2'b10);
        do_read("unal", 32'h0000_000C, 3'b100, W1, 2'b00);
        do_read("hi", 32'h8000_0000, 3'b100, 64'd0, 2'b10);

        // Data access allowed on the second build.
        step();
        bus_d.arvalid = 1'b1; bus_d.araddr = 32'h0000_0008; bus_d.arprot = 3'b000;
        step();
        bus_d.arvalid = 1'b0;
        @(negedge clk);
        check("d_rvalid", {63'd0, bus_d.rvalid}, 64'd1);
        check("d_rdata", bus_d.rdata, W1);
        check("d_rresp", {62'd0, bus_d.rresp}, 64'd0);
        step();
        @(negedge clk);
        check("d_lowpower", bus_d.rdata, 64'd0);

        // Streaming under RREADY back-pressure against a reference queue.
        req_i = 0; got = 0; outst = 0; cyc = 0;
        prev_stall = 1'b0; saw_full = 1'b0; held_d = 64'd0; held_r = 2'b00;
        while (got < 6 && cyc < 60) begin
            step();
            bus.arvalid = (req_i < 6);
            bus.araddr  = s_addr[(req_i < 6) ? req_i : 0];
            bus.arprot  = 3'b100;
            bus.rready  = pat[cyc % 7];
            @(negedge clk);
            check("s_arready", {63'd0, bus.arready}, {63'd0, outst < 2});
            check("s_rvalid", {63'd0, bus.rvalid}, {63'd0, outst > 0});
            if (prev_stall) begin
                check("s_hold_data", bus.rdata, held_d);
                check("s_hold_resp", {62'd0, bus.rresp}, {62'd0, held_r});
            end
            if (!bus.arready) saw_full = 1'b1;
            hs   = bus.arvalid && bus.arready;
            beat = bus.rvalid && bus.rready;
            if (beat) begin
                check("s_data", bus.rdata, exp_q.pop_front());
                check("s_resp", {62'd0, bus.rresp}, {62'd0, expr_q.pop_front()});
                got++;
            end
            if (hs) begin
                exp_q.push_back(s_data[req_i]);
                expr_q.push_back(s_resp[req_i]);
                req_i++;
            end
            outst = outst + int'(hs) - int'(beat);
            prev_stall = bus.rvalid && !bus.rready;
            held_d = bus.rdata;
            held_r = bus.rresp;
            cyc++;
        end
        check("s_count", 64'(got), 64'd6);
        check("s_saw_full", {63'd0, saw_full}, 64'd1);
        step();
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        @(negedge clk);
        check("s_no_extra", {63'd0, bus.rvalid}, 64'd0);

        // Load and read of the same word in one cycle: read-first.
        step();
        bus.arvalid = 1'b1; bus.araddr = 32'h0000_0008; bus.arprot = 3'b100;
        ld_we = 1'b1; ld_addr = 9'd1; ld_data = WN;
        step();
        bus.arvalid = 1'b0;
        ld_we = 1'b0;
        @(negedge clk);
        check("ld_old", bus.rdata, W1);
        do_read("ld_new", 32'h0000_0008, 3'b100, WN, 2'b00);

        // Reset with one beat stalled in R and one request in the skid.
        step();
        bus.arvalid = 1'b1; bus.araddr = 32'h0000_0000; bus.rready = 1'b0;
        step();
        bus.araddr = 32'h0000_0008;
        step();
        bus.arvalid = 1'b0;
        aresetn = 1'b0;
        @(negedge clk);
        check("pre_rst_arready", {63'd0, bus.arready}, 64'd0);
        check("pre_rst_rvalid", {63'd0, bus.rvalid}, 64'd1);
        step();
        aresetn = 1'b1;
        @(negedge clk);
        check("post_rst_rvalid", {63'd0, bus.rvalid}, 64'd0);
        check("post_rst_arready", {63'd0, bus.arready}, 64'd1);
        bus.rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check("post_rst_stale", {63'd0, bus.rvalid}, 64'd0);
        end
        do_read("post_rst_read", 32'h0000_0010, 3'b100, W2, 2'b00);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
